data_mem_sized: RTL
===================

# data_mem_sized

Parametrised, byte-addressable data memory for the single-cycle/multi-cycle core datapath. It generalises the basic word data memory in three ways: configurable depth, byte/half/word accesses with sign or zero extension, and optional wait states with a `ready` handshake. It sits between the ALU address output and the write-back mux. A compile-time option selects whether misaligned accesses trap or are silently aligned.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, at least 4.
- `ADDR_W`, 32: address width.
- `WAIT_CYCLES`, 0: extra cycles per access, 0–15.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request.
- `addr`  in  ADDR_W  byte address.
- `write_data`  in  32  store data, right-aligned.
- `size`  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `unsigned_ld`  in  1  1 = zero-extend loads, 0 = sign-extend loads.
- `read_data`  out  32  extended load result, registered.
- `ready`  out  1  block idle and able to accept a request.
- `misaligned`  out  1  one-cycle pulse when an access is rejected.

## Operation
- A request is accepted at a rising edge when `ready` = 1 and `mem_read | mem_write` = 1. At that edge `addr`, `write_data`, `size` and `unsigned_ld` are captured.
- Simultaneous `mem_read` and `mem_write`: treated as a write. `read_data` is unchanged.
- Word index is `addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH_WORDS.
- Lanes are little-endian; `addr[1:0]` selects the byte lane.
  - Byte store writes lane `addr[1:0]`.
  - Half store writes lanes `{addr[1],0}` and `{addr[1],1}`.
  - Word store writes all four lanes.
  - Lanes not written are preserved.
- Loads extract the addressed byte or half, then sign- or zero-extend it to 32 bits per `unsigned_ld`. Word loads ignore `unsigned_ld`.
- FSM states:
  - IDLE: `ready` = 1. An accepted request moves to WAIT if `WAIT_CYCLES` > 0; otherwise it completes in the accept edge.
  - WAIT: a counter loads `WAIT_CYCLES` − 1 and decrements each cycle. When the counter reaches 0, the access completes and the FSM returns to IDLE.
- Completion means the store commits, or `read_data` updates. `read_data` holds its value until the next load completes.
- Memory contents are not cleared by `rst`. Simulation initialises the array to 0.

## Timing
- Reset values: `ready` = 1, `read_data` = 0, `misaligned` = 0, FSM = IDLE, counter = 0.
- `WAIT_CYCLES` = 0: accept at edge N. Write data is visible to a load accepted at edge N+1. `read_data` is valid after edge N. `ready` never deasserts.
- `WAIT_CYCLES` = W > 0: `ready` is low for exactly W cycles after the accept edge. Completion occurs at edge N+W, and `ready` is high again after that edge.
- Request inputs are ignored while `ready` = 0.
- `rst` during WAIT: the access is aborted. A pending store is discarded (memory unchanged) and `read_data` is cleared to 0.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned cases: a half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0.
  - Such an access is still accepted, but no memory write and no `read_data` update occur.
  - `misaligned` pulses high for one cycle after the completion edge.
  - Wait-state timing is unchanged.
- Undefined: `addr` low bits are forced to alignment (half: bit 0 cleared; word: bits 1:0 cleared) and the access proceeds. `misaligned` is tied to 0.

## Structure
- Package `dmem_pkg`:
  - `typedef enum logic [1:0] mem_size_t {SZ_B, SZ_H, SZ_W, SZ_RSV}`.
  - Lane-mask function mapping (size, addr[1:0]) to a 4-bit byte enable.
  - Load-extend function.
- Sub-module `dmem_array`: DEPTH_WORDS × 32 storage with a 4-bit byte-enable synchronous write and a registered read.
- The top level holds the FSM, wait counter, request capture and extension logic.

## Test plan
- Word store 0xABCD1234 to 0x4, then word load from 0x4 → `read_data` = 0xABCD1234.
- Byte store 0x80 to 0x9, then `lb` 0x9 → 0xFFFFFF80, `lbu` 0x9 → 0x00000080, word load 0x8 → 0x00008000. Lanes 0, 2 and 3 keep their prior value 0.
- Half store 0xBEEF to 0x12 after word 0x11223344 is at 0x10 → word load 0x10 returns 0xBEEF3344. `lh` 0x12 → 0xFFFFBEEF.
- `WAIT_CYCLES` = 2, load from 0x4 → `ready` low for 2 cycles, then `read_data` = 0xABCD1234. A request pulsed during the wait is ignored.
- With the macro, word store 0xDEADBEEF to 0x6 → `misaligned` pulses for one cycle and word 0x4 is unchanged. Without the macro, the same store writes word 0x4 = 0xDEADBEEF.
- Wrap with DEPTH_WORDS = 256: store 0x55555555 to 0x400 → load 0x0 returns 0x55555555. `rst` during WAIT of a store → memory unchanged, `ready` = 1 on the next cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the sized data memory.
// Byte-lane masks, store replication and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_RSV
  } mem_size_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } dmem_state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    mem_size_t   sz;
    logic        uns;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic [3:0] lane_mask(
    input mem_size_t  sz,
    input logic [1:0] off
  );
    logic [3:0] m;
    m = 4'b1111;
    unique case (sz)
      SZ_B: m = 4'b0001 << off;
      SZ_H: m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(
    input mem_size_t  sz,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    unique case (sz)
      SZ_B: r = 1'b0;
      SZ_H: r = off[0];
      default: r = |off;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] align_off(
    input mem_size_t  sz,
    input logic [1:0] off
  );
    logic [1:0] r;
    r = off;
    unique case (sz)
      SZ_B: r = off;
      SZ_H: r = {off[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Replicate right-aligned data so every lane sees its slice.
  function automatic logic [31:0] store_data(
    input mem_size_t   sz,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = wd;
    unique case (sz)
      SZ_B: r = {4{wd[7:0]}};
      SZ_H: r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(
    input mem_size_t   sz,
    input logic [1:0]  off,
    input logic        uns,
    input logic [31:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[7:0];
    unique case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    r = word;
    unique case (sz)
      SZ_B: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_H: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enable write and registered read.
// Contents survive reset; only the read register clears.
import dmem_pkg::*;

module dmem_array #(
  parameter  int DEPTH_WORDS = 256,
  localparam int IW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_sized.sv
// Sized data memory: FSM, wait counter, capture, extension.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
import dmem_pkg::*;

module data_mem_sized #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       write_data,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              misaligned
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam bit NOWAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD =
    4'(WAIT_CYCLES - 1);

  dmem_state_t       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  dmem_req_t         req_q, req_live, cur;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic              accept, complete, done;
  logic              bad, st_en, ld_en;
  logic [1:0]        off;
  logic [3:0]        be;
  logic [31:0]       rword;
  mem_size_t         ld_sz_q;
  logic [1:0]        ld_off_q;
  logic              ld_uns_q;
  logic              unused_hi;

  assign ready  = (state_q == ST_IDLE);
  assign accept = ready & (mem_read | mem_write);

  // A write wins when both strobes are set.
  assign req_live = '{
    rd:    mem_read & ~mem_write,
    wr:    mem_write,
    sz:    mem_size_t'(size),
    uns:   unsigned_ld,
    wdata: write_data
  };

  assign cur      = NOWAIT ? req_live : req_q;
  assign cur_addr = NOWAIT ? addr : addr_q;

  assign complete = NOWAIT ? accept :
    (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign done = complete & ~rst;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  assign bad = is_misaligned(cur.sz, cur_addr[1:0]);
  assign off = cur_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= done & bad;
    end
  end

  assign misaligned = mis_q;
`else
  assign bad = 1'b0;
  assign off = align_off(cur.sz, cur_addr[1:0]);
  assign misaligned = 1'b0;
`endif

  assign st_en = done & cur.wr & ~bad;
  assign ld_en = done & cur.rd & ~bad;
  assign be    = lane_mask(cur.sz, off);
  assign unused_hi = ^cur_addr[ADDR_W-1:IW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= '0;
      addr_q <= '0;
    end else if (accept) begin
      req_q  <= req_live;
      addr_q <= addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !NOWAIT) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_sz_q  <= SZ_W;
      ld_off_q <= 2'b00;
      ld_uns_q <= 1'b0;
    end else if (ld_en) begin
      ld_sz_q  <= cur.sz;
      ld_off_q <= off;
      ld_uns_q <= cur.uns;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (st_en),
    .re    (ld_en),
    .be    (be),
    .idx   (cur_addr[IW+1:2]),
    .wdata (store_data(cur.sz, cur.wdata)),
    .rdata (rword)
  );

  // Extension follows the registered word, so the result
  // holds until the next completed load.
  assign read_data =
    load_extend(ld_sz_q, ld_off_q, ld_uns_q, rword);

endmodule
